// File: rtl/sudoku_grid_param.sv
// Tile: one grid cell; on its turn picks the lowest free value above its current one.
// Latency: one cycle from myturn to passfwd (value found) or passbak (exhausted).
// Backpressure: none; a single token walks the chain so at most one tile is active.
module sudoku_tile #(
  parameter int LEN = 9
) (
  input  logic           clock,
  input  logic           tile_rst,
  input  logic           myturn,
  input  logic [LEN-1:0] valcannotbe,
  output logic [LEN-1:0] value,
  output logic           passfwd,
  output logic           passbak
);
  logic [LEN-1:0] allowed;
  logic [LEN-1:0] avail;
  logic [LEN-1:0] pick;

  // An empty tile may take anything; a filled tile resumes strictly above its value.
  always_comb begin
    allowed = (value == '0) ? '1 : ~(value | (value - LEN'(1)));
    avail   = allowed & ~valcannotbe;
    pick    = avail & (~avail + LEN'(1));
  end

  always_ff @(posedge clock) begin
    if (tile_rst) begin
      value   <= '0;
      passfwd <= 1'b0;
      passbak <= 1'b0;
    end else begin
      passfwd <= 1'b0;
      passbak <= 1'b0;
      if (myturn) begin
        value <= pick;
        if (pick != '0) passfwd <= 1'b1;
        else            passbak <= 1'b1;
      end
    end
  end
endmodule

// Rowbias: OR-reduces the one-hot values of one row into its occupancy mask.
// Latency: combinational.
// Backpressure: none.
module sudoku_rowbias #(
  parameter int LEN = 9
) (
  input  logic [LEN-1:0][LEN-1:0] row_vals,
  output logic [LEN-1:0]          row_occ
);
  always_comb begin
    row_occ = '0;
    for (int k = 0; k < LEN; k++) row_occ = row_occ | row_vals[k];
  end
endmodule

// Parametrised backtracking sudoku solver with cycle counter, timeout and serial readout.
// Latency: start -> CLEAR -> START -> WAIT; one WAIT cycle per tile step of the token.
// Backpressure: readout beats advance only on rd_valid & rd_ready; index/value held otherwise.
module sudoku_grid_param #(
  parameter  int ORD        = 3,
  parameter  int CYC_W      = 32,
  parameter  int MAX_CYCLES = 0,
  localparam int LEN        = ORD * ORD,
  localparam int AREA       = LEN * LEN,
  localparam int VAL_W      = $clog2(LEN + 1),
  localparam int IDX_W      = (AREA > 1) ? $clog2(AREA) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             success,
  output logic             timedout,
  output logic [CYC_W-1:0] cycles,
  input  logic             rd_start,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [IDX_W-1:0] rd_index,
  output logic [VAL_W-1:0] rd_value,
  output logic             rd_last
);
  typedef enum logic [7:0] {
    S_IDLE    = 8'b0000_0001,
    S_CLEAR   = 8'b0000_0010,
    S_START   = 8'b0000_0100,
    S_WAIT    = 8'b0000_1000,
    S_DSUCC   = 8'b0001_0000,
    S_DFAIL   = 8'b0010_0000,
    S_DTO     = 8'b0100_0000,
    S_READOUT = 8'b1000_0000
  } state_t;

  localparam logic [CYC_W-1:0] TO_LIMIT = CYC_W'((MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0);

  state_t state_q, state_d;
  logic [CYC_W-1:0] cycles_q;
  logic [IDX_W-1:0] rd_index_q;

  logic [AREA-1:0][LEN-1:0] tval;
  logic [AREA-1:0]          passfwd;
  logic [AREA-1:0]          passbak;
  logic [LEN-1:0]           cannot  [AREA];
  logic [LEN-1:0]           row_occ [LEN];
  logic [LEN-1:0]           col_occ [LEN];
  logic [LEN-1:0]           blk_occ [LEN];
  logic                     tile_rst;
  logic                     timeout_hit;
  logic                     last_beat;
  logic [LEN-1:0]           sel_val;
  logic [VAL_W-1:0]         enc_val;

  assign tile_rst = reset | (state_q == S_CLEAR);

  for (genvar r = 0; r < LEN; r++) begin : g_row
    sudoku_rowbias #(.LEN(LEN)) u_rowbias (
      .row_vals (tval[r*LEN +: LEN]),
      .row_occ  (row_occ[r])
    );
  end

  always_comb begin
    for (int k = 0; k < LEN; k++) begin
      col_occ[k] = '0;
      blk_occ[k] = '0;
    end
    for (int r = 0; r < LEN; r++) begin
      for (int c = 0; c < LEN; c++) begin
        col_occ[c]                     = col_occ[c] | tval[r*LEN + c];
        blk_occ[(r/ORD)*ORD + (c/ORD)] = blk_occ[(r/ORD)*ORD + (c/ORD)] | tval[r*LEN + c];
      end
    end
  end

  // Token chain: forward from the previous tile, backward from the next one.
  for (genvar i = 0; i < AREA; i++) begin : g_tile
    localparam int R = i / LEN;
    localparam int C = i % LEN;
    localparam int B = (R / ORD) * ORD + (C / ORD);
    logic turn_fwd;
    logic turn_bak;

    if (i == 0) begin : g_first
      assign turn_fwd = (state_q == S_START);
    end else begin : g_next
      assign turn_fwd = passfwd[i-1];
    end

    if (i == AREA - 1) begin : g_last
      assign turn_bak = 1'b0;
    end else begin : g_prev
      assign turn_bak = passbak[i+1];
    end

    assign cannot[i] = row_occ[R] | col_occ[C] | blk_occ[B];

    sudoku_tile #(.LEN(LEN)) u_tile (
      .clock       (clock),
      .tile_rst    (tile_rst),
      .myturn      (turn_fwd | turn_bak),
      .valcannotbe (cannot[i]),
      .value       (tval[i]),
      .passfwd     (passfwd[i]),
      .passbak     (passbak[i])
    );
  end

  assign timeout_hit = (MAX_CYCLES != 0) && (cycles_q == TO_LIMIT);
  assign last_beat   = (rd_index_q == IDX_W'(AREA - 1));

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CLEAR;
      S_CLEAR:   state_d = S_START;
      S_START:   state_d = S_WAIT;
      S_WAIT: begin
        if (passbak[0])             state_d = S_DFAIL;
        else if (passfwd[AREA-1])   state_d = S_DSUCC;
        else if (timeout_hit)       state_d = S_DTO;
      end
      S_DSUCC: begin
        if (start)         state_d = S_CLEAR;
        else if (rd_start) state_d = S_READOUT;
      end
      S_DFAIL:   if (start) state_d = S_CLEAR;
      S_DTO:     if (start) state_d = S_CLEAR;
      S_READOUT: if (rd_ready && last_beat) state_d = S_DSUCC;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycles_q   <= '0;
      rd_index_q <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          cycles_q   <= '0;
          rd_index_q <= '0;
        end
        S_WAIT:    if (cycles_q != '1) cycles_q <= cycles_q + CYC_W'(1);
        S_DSUCC:   if (rd_start && !start) rd_index_q <= '0;
        S_READOUT: if (rd_ready) rd_index_q <= last_beat ? '0 : rd_index_q + IDX_W'(1);
        default: ;
      endcase
    end
  end

  // Lowest set bit wins if a tile ever holds more than one bit.
  always_comb begin
    sel_val = tval[rd_index_q];
    enc_val = '0;
    for (int k = LEN - 1; k >= 0; k--) begin
      if (sel_val[k]) enc_val = VAL_W'(k + 1);
    end
  end

  assign busy     = (state_q == S_CLEAR) || (state_q == S_START) || (state_q == S_WAIT);
  assign done     = (state_q == S_DSUCC) || (state_q == S_DFAIL) || (state_q == S_DTO) ||
                    (state_q == S_READOUT);
  assign success  = (state_q == S_DSUCC) || (state_q == S_READOUT);
  assign timedout = (state_q == S_DTO);
  assign cycles   = cycles_q;
  assign rd_valid = (state_q == S_READOUT);
  assign rd_index = rd_index_q;
  assign rd_value = rd_valid ? enc_val : '0;
  assign rd_last  = rd_valid && last_beat;

  a_tile_onehot: assert property (@(posedge clock) disable iff (reset)
    (state_q == S_READOUT) |-> $onehot0(sel_val));
endmodule

// File: tb/tb_sudoku_grid_param.sv
// Bench for sudoku_grid_param: ORD=2 solve/readout/relaunch/reset, ORD=3 timeout, ORD=1 corner.
module tb_sudoku_grid_param;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int idx;
    int val;
    bit last;
  } beat_t;

  beat_t qa[$];
  beat_t qc[$];
  int    got_a [16];
  // Lowest-first row-major fill of an empty 4x4 grid needs no backtracking.
  int    grid2 [16] = '{1, 2, 3, 4,  3, 4, 1, 2,  2, 1, 4, 3,  4, 3, 2, 1};

  // ORD=2, no timeout
  logic        a_reset, a_start, a_rd_start, a_rd_ready;
  logic        a_busy, a_done, a_success, a_timedout, a_rd_valid, a_rd_last;
  logic [31:0] a_cycles;
  logic [3:0]  a_rd_index;
  logic [2:0]  a_rd_value;

  // ORD=3, timeout after 4 WAIT cycles
  logic        b_reset, b_start, b_rd_start, b_rd_ready;
  logic        b_busy, b_done, b_success, b_timedout, b_rd_valid, b_rd_last;
  logic [31:0] b_cycles;
  logic [6:0]  b_rd_index;
  logic [3:0]  b_rd_value;

  // ORD=1
  logic        c_reset, c_start, c_rd_start, c_rd_ready;
  logic        c_busy, c_done, c_success, c_timedout, c_rd_valid, c_rd_last;
  logic [31:0] c_cycles;
  logic [0:0]  c_rd_index;
  logic [0:0]  c_rd_value;

  sudoku_grid_param #(.ORD(2), .CYC_W(32), .MAX_CYCLES(0)) dut_a (
    .clock(clock), .reset(a_reset), .start(a_start), .busy(a_busy), .done(a_done),
    .success(a_success), .timedout(a_timedout), .cycles(a_cycles), .rd_start(a_rd_start),
    .rd_valid(a_rd_valid), .rd_ready(a_rd_ready), .rd_index(a_rd_index),
    .rd_value(a_rd_value), .rd_last(a_rd_last)
  );

  sudoku_grid_param #(.ORD(3), .CYC_W(32), .MAX_CYCLES(4)) dut_b (
    .clock(clock), .reset(b_reset), .start(b_start), .busy(b_busy), .done(b_done),
    .success(b_success), .timedout(b_timedout), .cycles(b_cycles), .rd_start(b_rd_start),
    .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_index(b_rd_index),
    .rd_value(b_rd_value), .rd_last(b_rd_last)
  );

  sudoku_grid_param #(.ORD(1), .CYC_W(32), .MAX_CYCLES(0)) dut_c (
    .clock(clock), .reset(c_reset), .start(c_start), .busy(c_busy), .done(c_done),
    .success(c_success), .timedout(c_timedout), .cycles(c_cycles), .rd_start(c_rd_start),
    .rd_valid(c_rd_valid), .rd_ready(c_rd_ready), .rd_index(c_rd_index),
    .rd_value(c_rd_value), .rd_last(c_rd_last)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitors: pop one expected beat per accepted handshake.
  always @(negedge clock) begin
    beat_t e;
    if (a_rd_valid && a_rd_ready) begin
      if (qa.size() == 0) check("a_unexpected_beat", 1, 0);
      else begin
        e = qa.pop_front();
        check("a_rd_index", a_rd_index, e.idx);
        check("a_rd_value", a_rd_value, e.val);
        check("a_rd_last", a_rd_last, e.last);
        got_a[a_rd_index] = a_rd_value;
      end
    end
  end

  always @(negedge clock) begin
    beat_t e;
    if (c_rd_valid && c_rd_ready) begin
      if (qc.size() == 0) check("c_unexpected_beat", 1, 0);
      else begin
        e = qc.pop_front();
        check("c_rd_index", c_rd_index, e.idx);
        check("c_rd_value", c_rd_value, e.val);
        check("c_rd_last", c_rd_last, e.last);
      end
    end
  end

  task automatic push_a;
    for (int i = 0; i < 16; i++) qa.push_back('{idx: i, val: grid2[i], last: (i == 15)});
  endtask

  task automatic check_a_zero(input string name);
    check(name, {a_busy, a_done, a_success, a_timedout, a_rd_valid, a_rd_last,
                 a_cycles, a_rd_index, a_rd_value}, 0);
  endtask

  task automatic solve_a(input string name);
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    check({name, "_busy"}, a_busy, 1);
    check({name, "_not_done"}, a_done, 0);
    for (int k = 0; k < 300 && !a_done; k++) tick;
    check({name, "_done"}, a_done, 1);
    check({name, "_success"}, a_success, 1);
    check({name, "_timedout"}, a_timedout, 0);
    check({name, "_cycles"}, a_cycles, 16);
  endtask

  task automatic readout_a_full(input string name);
    push_a;
    a_rd_ready = 1'b1;
    a_rd_start = 1'b1;
    tick;
    a_rd_start = 1'b0;
    check({name, "_valid"}, a_rd_valid, 1);
    for (int k = 0; k < 60 && a_rd_valid; k++) tick;
    check({name, "_ended"}, a_rd_valid, 0);
    check({name, "_drained"}, qa.size(), 0);
    check({name, "_back_to_success"}, a_success, 1);
  endtask

  task automatic perm_a;
    int mr, mc, mb;
    for (int g = 0; g < 4; g++) begin
      mr = 0; mc = 0; mb = 0;
      for (int j = 0; j < 4; j++) begin
        int vr, vc, vb;
        vr = got_a[g*4 + j];
        vc = got_a[j*4 + g];
        vb = got_a[((g/2)*2 + j/2)*4 + (g%2)*2 + j%2];
        if (vr >= 1 && vr <= 4) mr |= 1 << (vr - 1);
        if (vc >= 1 && vc <= 4) mc |= 1 << (vc - 1);
        if (vb >= 1 && vb <= 4) mb |= 1 << (vb - 1);
      end
      check("a_row_perm", mr, 15);
      check("a_col_perm", mc, 15);
      check("a_blk_perm", mb, 15);
    end
  endtask

  initial begin
    a_reset = 1'b1; a_start = 1'b0; a_rd_start = 1'b0; a_rd_ready = 1'b0;
    b_reset = 1'b1; b_start = 1'b0; b_rd_start = 1'b0; b_rd_ready = 1'b0;
    c_reset = 1'b1; c_start = 1'b0; c_rd_start = 1'b0; c_rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) got_a[i] = 0;
    tick;
    tick;
    check_a_zero("a_reset_state");
    check("b_reset_state", {b_busy, b_done, b_success, b_timedout, b_rd_valid, b_rd_last,
                            b_cycles, b_rd_index, b_rd_value}, 0);
    check("c_reset_state", {c_busy, c_done, c_success, c_timedout, c_rd_valid, c_rd_last,
                            c_cycles, c_rd_index, c_rd_value}, 0);
    a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
    tick;

    // ORD=2 solve, then readout with a 3-cycle stall at index 5
    solve_a("a_solve1");
    push_a;
    a_rd_ready = 1'b1;
    a_rd_start = 1'b1;
    tick;
    a_rd_start = 1'b0;
    for (int k = 0; k < 40 && a_rd_index != 5; k++) tick;
    a_rd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("a_bp_index", a_rd_index, 5);
      check("a_bp_value", a_rd_value, grid2[5]);
      check("a_bp_valid", a_rd_valid, 1);
    end
    a_rd_ready = 1'b1;
    tick;
    check("a_bp_resume_index", a_rd_index, 6);
    for (int k = 0; k < 40 && a_rd_valid; k++) tick;
    check("a_bp_readout_ended", a_rd_valid, 0);
    check("a_bp_drained", qa.size(), 0);
    check("a_bp_index_reset", a_rd_index, 0);
    perm_a;

    // Relaunch from DONE_SUCCESS; the second grid must match the first
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    check("a_relaunch_done_drop", a_done, 0);
    check("a_relaunch_busy", a_busy, 1);
    tick;
    check("a_relaunch_cycles_cleared", a_cycles, 0);
    for (int k = 0; k < 300 && !a_done; k++) tick;
    check("a_relaunch_success", a_success, 1);
    check("a_relaunch_cycles", a_cycles, 16);
    readout_a_full("a_readout2");

    // Reset in the middle of a readout, then a clean solve
    push_a;
    a_rd_ready = 1'b1;
    a_rd_start = 1'b1;
    tick;
    a_rd_start = 1'b0;
    for (int k = 0; k < 40 && a_rd_index != 7; k++) tick;
    check("a_mid_index", a_rd_index, 7);
    a_reset = 1'b1;
    a_rd_ready = 1'b0;
    qa.delete();
    tick;
    check_a_zero("a_mid_reset_outputs");
    a_reset = 1'b0;
    tick;
    check_a_zero("a_idle_after_reset");
    solve_a("a_solve3");
    readout_a_full("a_readout3");

    // ORD=3 timeout after exactly 4 WAIT cycles
    b_start = 1'b1;
    tick;
    b_start = 1'b0;
    check("b_busy_after_start", b_busy, 1);
    for (int k = 0; k < 5; k++) begin
      tick;
      check("b_not_done_early", b_done, 0);
    end
    tick;
    check("b_done", b_done, 1);
    check("b_success", b_success, 0);
    check("b_timedout", b_timedout, 1);
    check("b_cycles", b_cycles, 4);
    check("b_busy_cleared", b_busy, 0);
    b_rd_ready = 1'b1;
    b_rd_start = 1'b1;
    tick;
    b_rd_start = 1'b0;
    check("b_rd_start_ignored", b_rd_valid, 0);
    check("b_still_timedout", b_timedout, 1);
    tick;
    check("b_rd_valid_stays_low", b_rd_valid, 0);

    // ORD=1 corner: single tile solves to 1
    c_start = 1'b1;
    tick;
    c_start = 1'b0;
    for (int k = 0; k < 20 && !c_done; k++) tick;
    check("c_success", c_success, 1);
    check("c_cycles", c_cycles, 1);
    qc.push_back('{idx: 0, val: 1, last: 1'b1});
    c_rd_ready = 1'b1;
    c_rd_start = 1'b1;
    tick;
    c_rd_start = 1'b0;
    check("c_rd_valid", c_rd_valid, 1);
    for (int k = 0; k < 10 && c_rd_valid; k++) tick;
    check("c_readout_ended", c_rd_valid, 0);
    check("c_drained", qc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got unfinished run, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sudoku_grid_param.md
Name: sudoku_grid_param

Overview:
Parametrised successor to the fixed-size sudoku grid. It instantiates an LEN x LEN network of tile and rowbias modules, with LEN = ORD*ORD, and runs the same backtracking pass-forward/pass-back chain. It adds the following, which the fixed grid lacks:
- restart from any done state;
- a cycle counter with an optional timeout;
- a serial, back-pressurable readout port for the solved grid.

Parameters:
ORD, 3, grid order; LEN = ORD*ORD, AREA = LEN*LEN (derived localparams)
CYC_W, 32, width of the solve cycle counter
MAX_CYCLES, 0, WAIT-cycle limit before timeout; 0 disables timeout
(derived) VAL_W = $clog2(LEN+1); IDX_W = $clog2(AREA)

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high; one clock, reset is sync active-high
start  in  1  launch/relaunch a solve (level sampled)
busy  out  1  high in CLEAR/START/WAIT
done  out  1  high in DONE_SUCCESS, DONE_FAILURE, DONE_TIMEOUT, READOUT
success  out  1  high in DONE_SUCCESS and READOUT
timedout  out  1  high in DONE_TIMEOUT
cycles  out  CYC_W  WAIT cycles consumed by the current/last solve
rd_start  in  1  request serial readout of solution
rd_valid  out  1  readout beat valid
rd_ready  in  1  consumer accepts beat
rd_index  out  IDX_W  row-major tile index of current beat (r*LEN+c)
rd_value  out  VAL_W  tile value, binary 1..LEN; 0 = empty
rd_last  out  1  high with beat AREA-1

Behaviour:
- Reset values: all outputs 0; state IDLE; tiles and rowbias units held in reset.
- States: IDLE, CLEAR, START, WAIT, DONE_SUCCESS, DONE_FAILURE, DONE_TIMEOUT, READOUT (one-hot encoding).
- Internal tile reset = reset | (state==CLEAR). CLEAR lasts exactly 1 cycle.
- IDLE: start -> CLEAR.
- CLEAR -> START. cycles <= 0. rd_index <= 0.
- START: myturn of tile 0 asserted for this 1 cycle. START -> WAIT.
- WAIT: cycles increments each cycle, saturating at all-ones. Transition priority:
  1. passbak of tile 0 -> DONE_FAILURE;
  2. passfwd of tile AREA-1 -> DONE_SUCCESS;
  3. MAX_CYCLES!=0 and cycles==MAX_CYCLES-1 -> DONE_TIMEOUT;
  4. otherwise stay in WAIT.
- Latency and timeout timing:
  - start sampled high in IDLE at edge t -> busy=1 from t+1, START at t+2, WAIT at t+3.
  - Timeout: done asserts after exactly MAX_CYCLES WAIT cycles, with cycles==MAX_CYCLES.
- Any DONE_* state holds until start or reset.
  - start -> CLEAR (relaunch). done/success/timedout drop the cycle after start is sampled.
  - cycles is retained in DONE_* until CLEAR.
- rd_start:
  - honoured only in DONE_SUCCESS -> READOUT with rd_index=0;
  - ignored in every other state, with no output change.
- READOUT:
  - rd_valid=1.
  - rd_value and rd_last are combinational from registered rd_index.
  - Beat accepted when rd_valid & rd_ready.
  - On acceptance with rd_index<AREA-1: rd_index++.
  - On acceptance of AREA-1: rd_index <= 0, rd_valid drops next cycle, state returns to DONE_SUCCESS. Readout is repeatable.
  - While rd_ready=0: rd_index/rd_value/rd_last are held stable.
  - start is ignored in READOUT.
- Value encoding:
  - one-hot bit k of the tile value -> k+1; all-zero -> 0;
  - multi-hot is illegal; lowest set bit wins. An assertion flags multi-hot in simulation.
- Occupancy networks:
  - row/col/block OR of tile values feeds each tile's valcannotbe mask;
  - block index b = (r/ORD)*ORD + c/ORD;
  - all widths scale with LEN.
- Reset mid-operation (any state, incl. READOUT with beats pending): next cycle IDLE, all outputs 0; no partial beat is reissued.
- ORD=1 is legal: a single tile solves to value 1.

Test Plan:
- ORD=2, MAX_CYCLES=0:
  - stimulus: pulse start, wait for done, then rd_start with rd_ready=1;
  - required: success=1, timedout=0, cycles>0;
  - 16 beats, rd_index 0..15, rd_last only on beat 16;
  - every row, column and 2x2 block is a permutation of 1..4.
- Backpressure: during readout, drop rd_ready for 3 cycles at rd_index=5 -> rd_index=5 and rd_value are unchanged for all 3 cycles; beat 6 follows 1 cycle after rd_ready rises; no beat is skipped or duplicated.
- Timeout: ORD=3, MAX_CYCLES=4, start -> DONE_TIMEOUT at t+7, with done=1, success=0, timedout=1, cycles=4; rd_start is ignored (rd_valid stays 0).
- Relaunch: in DONE_SUCCESS assert start -> done=0 and busy=1 the next cycle, cycles=0 after CLEAR; the second solve reaches DONE_SUCCESS with a grid identical to the first.
- Reset mid-readout: assert reset at beat 7 -> the next cycle all outputs are 0 and state is IDLE; a subsequent start solves normally.
- ORD=1 corner: start -> DONE_SUCCESS; readout gives 1 beat, rd_index=0, rd_value=1, rd_last=1.
